// File: rtl/lsf_pkg.sv
// lsf_pkg: shared types and helpers for the level sensor filter.
//   lsf_state_t : validity FSM states (OK, SUSPECT, FAULT)
//   lsf_valid() : true for the thermometer codes 000, 001, 011, 111
package lsf_pkg;

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_SUSPECT = 2'd1,
      ST_FAULT   = 2'd2
   } lsf_state_t;

   function automatic logic lsf_valid(input logic [2:0] code);
      logic ok;
      ok = 1'b0;
      case (code)
         3'b000, 3'b001, 3'b011, 3'b111: ok = 1'b1;
         default:                        ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsf_debounce.sv
// lsf_debounce: single-bit 2-flop synchronizer followed by a debouncer.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   raw   : asynchronous contact input
//   db    : accepted (debounced) value; changes only after the synchronized
//           input has differed from it for DEBOUNCE_CYCLES consecutive samples
module lsf_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic db
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         db    <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == db) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            // this sample is the DEBOUNCE_CYCLES-th consecutive difference
            db  <= sync2;
            cnt <= '0;
         end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/level_sensor_filter.sv
// level_sensor_filter: filters three raw reservoir level contacts into a
// thermometer-coded level for the flow controller.
//   clk       : rising-edge clock
//   reset     : synchronous, active-high
//   raw_s     : raw contacts, bit i = water above sensor i (asynchronous)
//   s         : filtered level, updated only from valid debounced codes
//   level_chg : one-cycle pulse in the cycle s takes a new value
//   fault     : high while the validity FSM is in FAULT
// Build option: define LSF_STICKY_FAULT_EN to make FAULT absorbing (fault
// stays high and s stays frozen until reset).
module level_sensor_filter
   import lsf_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned FAULT_CYCLES    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] raw_s,
   output logic [2:0] s,
   output logic       level_chg,
   output logic       fault
);

`ifdef LSF_STICKY_FAULT_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   localparam int unsigned FCNT_W = $clog2(FAULT_CYCLES + 1);

   logic [2:0]        db;
   logic              db_ok;
   logic              s_upd;
   lsf_state_t        state_q, state_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;

   for (genvar i = 0; i < 3; i++) begin : g_bit
      lsf_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk  (clk),
         .reset(reset),
         .raw  (raw_s[i]),
         .db   (db[i])
      );
   end

   assign db_ok = lsf_valid(db);
   assign fault = (state_q == ST_FAULT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_OK;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // fcnt counts invalid cycles spent in SUSPECT
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      unique case (state_q)
         ST_OK: begin
            fcnt_d = '0;
            if (!db_ok) state_d = ST_SUSPECT;
         end
         ST_SUSPECT: begin
            if (db_ok) begin
               state_d = ST_OK;
               fcnt_d  = '0;
            end else if (fcnt_q == FCNT_W'(FAULT_CYCLES - 1)) begin
               state_d = ST_FAULT;
               fcnt_d  = '0;
            end else if (fcnt_q != '1) begin
               fcnt_d = fcnt_q + 1'b1;
            end
         end
         ST_FAULT: begin
            fcnt_d = '0;
            if (db_ok && !STICKY) state_d = ST_OK;
         end
         default: begin
            state_d = ST_OK;
            fcnt_d  = '0;
         end
      endcase
   end

   assign s_upd = db_ok && !(STICKY && (state_q == ST_FAULT));

   always_ff @(posedge clk) begin
      if (reset) begin
         s         <= '0;
         level_chg <= 1'b0;
      end else begin
         level_chg <= 1'b0;
         if (s_upd) begin
            s         <= db;
            level_chg <= (db != s);
         end
      end
   end

endmodule

// File: tb/tb_level_sensor_filter.sv
// tb_level_sensor_filter: directed and randomized checks of level_sensor_filter
// against a window-based reference model of the filtering rules.
module tb_level_sensor_filter;

`ifdef LSF_STICKY_FAULT_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   localparam int unsigned D = 4;
   localparam int unsigned F = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] raw_s = 3'b000;
   logic [2:0] s;
   logic       level_chg;
   logic       fault;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // reference model state
   logic [2:0]  hist[$];
   logic [2:0]  m_db, m_s;
   logic        m_lc, m_fault;
   int unsigned m_run;

   level_sensor_filter #(
      .DEBOUNCE_CYCLES(D),
      .FAULT_CYCLES   (F)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .raw_s    (raw_s),
      .s        (s),
      .level_chg(level_chg),
      .fault    (fault)
   );

   always #5 clk = ~clk;

   function automatic logic is_valid(input logic [2:0] v);
      return (v == 3'b000) || (v == 3'b001) || (v == 3'b011) || (v == 3'b111);
   endfunction

   task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock edge of the model. A raw value reaches the debouncer two edges
   // after it is applied; a bit is accepted once its last D delayed samples
   // all disagree with the accepted value.
   task automatic model_edge(input logic rst, input logic [2:0] r);
      logic [2:0]  odb;
      logic        ov;
      logic        all_diff;
      int unsigned n;
      if (rst) begin
         m_db = '0; m_s = '0; m_lc = 1'b0; m_fault = 1'b0; m_run = 0;
         hist.delete();
         for (int unsigned i = 0; i < D + 2; i++) hist.push_back(3'b000);
         return;
      end
      hist.push_back(r);
      if (hist.size() > D + 4) void'(hist.pop_front());
      odb  = m_db;
      ov   = is_valid(odb);
      m_lc = 1'b0;
      if (ov && !(STICKY && m_fault)) begin
         m_lc = (odb != m_s);
         m_s  = odb;
      end
      m_run   = ov ? 0 : m_run + 1;
      m_fault = (STICKY && m_fault) || (m_run >= F + 1);
      n = hist.size();
      for (int unsigned b = 0; b < 3; b++) begin
         all_diff = 1'b1;
         for (int unsigned k = 0; k < D; k++)
            if (hist[n - 3 - k][b] == odb[b]) all_diff = 1'b0;
         if (all_diff) m_db[b] = ~odb[b];
      end
   endtask

   task automatic step(input logic [2:0] r, input logic rst);
      raw_s = r;
      reset = rst;
      @(posedge clk);
      model_edge(rst, r);
      #1;
      check("model_s", s, m_s);
      check("model_level_chg", {2'b00, level_chg}, {2'b00, m_lc});
      check("model_fault", {2'b00, fault}, {2'b00, m_fault});
   endtask

   task automatic steps(input logic [2:0] r, input int unsigned cnt);
      for (int unsigned i = 0; i < cnt; i++) step(r, 1'b0);
   endtask

   initial begin
      logic [2:0]  r;
      int unsigned h;
      logic [2:0]  valid_tab[4];
      valid_tab[0] = 3'b000; valid_tab[1] = 3'b001;
      valid_tab[2] = 3'b011; valid_tab[3] = 3'b111;

      // reset with raw = 000
      step(3'b000, 1'b1);
      step(3'b000, 1'b1);
      check("reset_s", s, 3'b000);
      check("reset_fault", {2'b00, fault}, 3'b000);
      check("reset_lc", {2'b00, level_chg}, 3'b000);
      steps(3'b000, 3);

      // 000 -> 001 held: s changes on the 7th edge
      steps(3'b001, 6);
      check("rise_edge6_s", s, 3'b000);
      steps(3'b001, 1);
      check("rise_edge7_s", s, 3'b001);
      check("rise_edge7_lc", {2'b00, level_chg}, 3'b001);
      steps(3'b001, 1);
      check("rise_edge8_lc", {2'b00, level_chg}, 3'b000);
      steps(3'b001, 4);

      // 3-cycle glitch on bit 1 is ignored
      steps(3'b011, 3);
      steps(3'b001, 10);
      check("glitch_s", s, 3'b001);

      // invalid 101: SUSPECT after edge 7, FAULT after 8 SUSPECT cycles
      steps(3'b101, 14);
      check("inv_edge14_fault", {2'b00, fault}, 3'b000);
      steps(3'b101, 1);
      check("inv_edge15_fault", {2'b00, fault}, 3'b001);
      check("inv_hold_s", s, 3'b001);
      steps(3'b101, 5);
      steps(3'b011, 10);
      check("recover_fault", {2'b00, fault}, STICKY ? 3'b001 : 3'b000);
      check("recover_s", s, STICKY ? 3'b001 : 3'b011);

      // reset during a pending change restarts the full 7-edge latency
      step(3'b000, 1'b1);
      steps(3'b001, 5);
      step(3'b001, 1'b1);
      check("midreset_s", s, 3'b000);
      check("midreset_fault", {2'b00, fault}, 3'b000);
      steps(3'b001, 6);
      check("midreset_edge6_s", s, 3'b000);
      steps(3'b001, 1);
      check("midreset_edge7_s", s, 3'b001);

      // randomized holds, biased toward valid codes, with occasional resets
      for (int unsigned t = 0; t < 60; t++) begin
         r = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7))
                                        : valid_tab[$urandom_range(0, 3)];
         h = $urandom_range(1, 14);
         if ($urandom_range(0, 19) == 0) step(r, 1'b1);
         steps(r, h);
      end
      steps(3'b000, 20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
